// File: rtl/jt03_wrseq_pkg.sv
// Shared types and defaults for the jt03 register-write sequencer.
package jt03_wrseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADR   = 3'd1,
    ST_AWAIT = 3'd2,
    ST_DAT   = 3'd3,
    ST_DWAIT = 3'd4
  } state_e;

  localparam int ADR_WAIT_DEF  = 6;
  localparam int DATA_WAIT_DEF = 24;

  typedef struct packed {
    logic [7:0] regn;
    logic [7:0] val;
  } entry_t;

endpackage

// File: rtl/jt03_wrseq_fifo.sv
// Synchronous FIFO of {reg,val} entries; head word is visible combinationally.
module jt03_wrseq_fifo
  import jt03_wrseq_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;
  entry_t        mem_q [2**AW];

  assign full  = level_q[AW];
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      // The popped entry is already held by the sequencer, so flush wins here.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
      else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jt03_wrseq.sv
// YM2203 write sequencer: queues host writes and replays them as address/data
// strobes with the chip's mandatory wait after each.
module jt03_wrseq
  import jt03_wrseq_pkg::*;
#(
  parameter int AW        = 2,
  parameter int ADR_WAIT  = ADR_WAIT_DEF,
  parameter int DATA_WAIT = DATA_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_reg,
  input  logic [7:0]    req_val,
  output logic [AW:0]   fifo_level,
  output logic          busy,
  output logic [7:0]    chip_din,
  output logic          chip_addr,
  output logic          chip_cs_n,
  output logic          chip_wr_n
);

  localparam logic [7:0] ADR_LD = 8'(ADR_WAIT - 1);
  localparam logic [7:0] DAT_LD = 8'(DATA_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  entry_t     hold_q, hold_d;
  entry_t     head;
  logic       pop, full, empty;
  logic       cs_n_q, cs_n_d, wr_n_q, wr_n_d, addr_q, addr_d;
  logic [7:0] din_q, din_d;

  param_chk: assert property (@(posedge clk)
    (ADR_WAIT >= 1) && (ADR_WAIT <= 255) && (DATA_WAIT >= 1) && (DATA_WAIT <= 255));

  jt03_wrseq_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (pop),
    .flush (flush),
    .din   ({req_reg, req_val}),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign req_ready = !full;
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign chip_cs_n = cs_n_q;
  assign chip_wr_n = wr_n_q;
  assign chip_addr = addr_q;
  assign chip_din  = din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: if (!empty) begin
          pop     = 1'b1;
          hold_d  = head;
          state_d = ST_ADR;
        end
        ST_ADR: begin
          cnt_d   = ADR_LD;
          state_d = ST_AWAIT;
        end
        ST_AWAIT: if (cnt_q == 8'd0) state_d = ST_DAT;
                  else               cnt_d   = cnt_q - 8'd1;
        ST_DAT: begin
          cnt_d   = DAT_LD;
          state_d = ST_DWAIT;
        end
        ST_DWAIT: if (cnt_q == 8'd0) state_d = ST_IDLE;
                  else               cnt_d   = cnt_q - 8'd1;
        default: state_d = ST_IDLE;
      endcase
    end

    // Bus outputs are registered from the state being entered on this edge.
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    addr_d = 1'b0;
    din_d  = 8'h00;
    case (state_d)
      ST_ADR: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        din_d  = hold_d.regn;
      end
      ST_AWAIT: din_d = hold_d.regn;
      ST_DAT: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        addr_d = 1'b1;
        din_d  = hold_d.val;
      end
      ST_DWAIT: din_d = hold_d.val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

endmodule

// File: tb/tb_jt03_wrseq.sv
// Directed bench for jt03_wrseq: strobe timing, FIFO fill, flush, reset, cen stall.
module tb_jt03_wrseq;

  logic       clk, rst, cen, flush, req_valid, req_ready;
  logic [7:0] req_reg, req_val, chip_din;
  logic [2:0] fifo_level;
  logic       busy, chip_addr, chip_cs_n, chip_wr_n;

  int checks   = 0;
  int failures = 0;

  jt03_wrseq dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_reg    (req_reg),
    .req_val    (req_val),
    .fifo_level (fifo_level),
    .busy       (busy),
    .chip_din   (chip_din),
    .chip_addr  (chip_addr),
    .chip_cs_n  (chip_cs_n),
    .chip_wr_n  (chip_wr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cen_tick();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic wait_adr(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < 80) begin
      cen_tick();
      n++;
      if (!chip_cs_n && !chip_addr) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < 80) begin
      cen_tick();
      n++;
      if (!busy) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    req_valid = 1'b1;
    req_reg   = r;
    req_val   = v;
    step(1'b0);
    req_valid = 1'b0;
  endtask

  initial begin
    int   n;
    logic ok;
    int   strobes;

    rst = 1'b1; cen = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_reg = 8'h00; req_val = 8'h00;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    step(1'b0);

    // Reset state
    chk("rst_cs_n",  32'(chip_cs_n),  32'd1);
    chk("rst_wr_n",  32'(chip_wr_n),  32'd1);
    chk("rst_addr",  32'(chip_addr),  32'd0);
    chk("rst_din",   32'(chip_din),   32'h00);
    chk("rst_ready", 32'(req_ready),  32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);

    // Single write
    push(8'h28, 8'hF1);
    chk("sw_level1", 32'(fifo_level), 32'd1);
    chk("sw_busy1",  32'(busy),       32'd1);
    chk("sw_nocen",  32'(chip_cs_n),  32'd1);
    cen_tick();
    chk("sw_adr_cs",   32'(chip_cs_n),  32'd0);
    chk("sw_adr_wr",   32'(chip_wr_n),  32'd0);
    chk("sw_adr_addr", 32'(chip_addr),  32'd0);
    chk("sw_adr_din",  32'(chip_din),   32'h28);
    chk("sw_level0",   32'(fifo_level), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cen_tick();
      if (!(chip_cs_n && chip_wr_n && chip_din == 8'h28)) ok = 1'b0;
    end
    chk("sw_await_idle", 32'(ok), 32'd1);
    cen_tick();
    chk("sw_dat_cs",   32'(chip_cs_n), 32'd0);
    chk("sw_dat_wr",   32'(chip_wr_n), 32'd0);
    chk("sw_dat_addr", 32'(chip_addr), 32'd1);
    chk("sw_dat_din",  32'(chip_din),  32'hF1);
    ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cen_tick();
      if (!(chip_cs_n && chip_wr_n && busy && chip_din == 8'hF1)) ok = 1'b0;
    end
    chk("sw_dwait_idle", 32'(ok), 32'd1);
    cen_tick();
    chk("sw_busy_fall", 32'(busy), 32'd0);

    // Fill without cen
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(req_ready), 32'd1);
      push(8'h10 + 8'(i), 8'hA0 + 8'(i));
    end
    chk("fill_level4", 32'(fifo_level), 32'd4);
    chk("fill_ready0", 32'(req_ready),  32'd0);
    push(8'h14, 8'hA4);
    chk("fill_held", 32'(fifo_level), 32'd4);
    wait_adr("fill_adr0", n);
    chk("fill_first_lat", 32'(n),        32'd1);
    chk("fill_din0",      32'(chip_din), 32'h10);
    for (int k = 1; k < 4; k++) begin
      wait_adr("fill_adr", n);
      chk("fill_gap", 32'(n),        32'd33);
      chk("fill_din", 32'(chip_din), 32'h10 + 32'(k));
    end
    wait_idle("fill_idle", n);
    chk("fill_tail", 32'(n), 32'd32);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      cen_tick();
      if (!chip_cs_n) strobes++;
    end
    chk("fill_no_5th", 32'(strobes), 32'd0);

    // Simultaneous push and pop
    push(8'h20, 8'hB0);
    req_valid = 1'b1; req_reg = 8'h21; req_val = 8'hB1;
    step(1'b1);
    req_valid = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd1);
    chk("pp_cs",    32'(chip_cs_n),  32'd0);
    chk("pp_din",   32'(chip_din),   32'h20);
    step(1'b0);
    wait_adr("pp_adr2", n);
    chk("pp_gap",  32'(n),        32'd33);
    chk("pp_din2", 32'(chip_din), 32'h21);
    wait_idle("pp_idle", n);
    chk("pp_tail", 32'(n), 32'd32);

    // Flush during AWAIT, with a concurrent push that must be dropped
    push(8'h30, 8'hC0);
    push(8'h31, 8'hC1);
    push(8'h32, 8'hC2);
    chk("fl_level3", 32'(fifo_level), 32'd3);
    cen_tick();
    chk("fl_adr_din", 32'(chip_din),   32'h30);
    chk("fl_level2",  32'(fifo_level), 32'd2);
    cen_tick();
    cen_tick();
    flush = 1'b1;
    req_valid = 1'b1; req_reg = 8'h33; req_val = 8'hC3;
    step(1'b0);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_level0", 32'(fifo_level), 32'd0);
    chk("fl_busy",   32'(busy),       32'd1);
    for (int i = 0; i < 4; i++) cen_tick();
    cen_tick();
    chk("fl_dat_cs",   32'(chip_cs_n), 32'd0);
    chk("fl_dat_addr", 32'(chip_addr), 32'd1);
    chk("fl_dat_din",  32'(chip_din),  32'hC0);
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      cen_tick();
      if (!chip_cs_n) strobes++;
    end
    chk("fl_no_more", 32'(strobes), 32'd0);
    chk("fl_idle",    32'(busy),    32'd0);

    // Reset during DAT strobe
    push(8'h40, 8'hD0);
    push(8'h41, 8'hD1);
    cen_tick();
    for (int i = 0; i < 7; i++) cen_tick();
    chk("rs_in_dat", 32'(chip_addr), 32'd1);
    chk("rs_dat_cs", 32'(chip_cs_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_cs_n",  32'(chip_cs_n),  32'd1);
    chk("rs_wr_n",  32'(chip_wr_n),  32'd1);
    chk("rs_addr",  32'(chip_addr),  32'd0);
    chk("rs_din",   32'(chip_din),   32'h00);
    chk("rs_level", 32'(fifo_level), 32'd0);
    chk("rs_busy",  32'(busy),       32'd0);
    chk("rs_ready", 32'(req_ready),  32'd1);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);

    // cen stall in DWAIT
    push(8'h50, 8'hE0);
    cen_tick();
    for (int i = 0; i < 7; i++) cen_tick();
    chk("st_dat_din", 32'(chip_din), 32'hE0);
    for (int i = 0; i < 4; i++) cen_tick();
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      if (!(chip_cs_n && chip_wr_n && busy && chip_din == 8'hE0)) ok = 1'b0;
    end
    chk("st_frozen", 32'(ok), 32'd1);
    wait_idle("st_idle", n);
    chk("st_remaining", 32'(n), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt03_wrseq.md
# jt03_wrseq

Register-write sequencer for the YM2203 wrapper (jt03). It accepts register/value pairs from a host through a valid/ready port and buffers them in a small FIFO. It then drives the chip's `cs_n`/`wr_n`/`addr`/`din` bus as an address strobe followed by a data strobe, inserting the mandatory chip wait time after each. It sits between a CPU or soft-player and jt03, so that no requester needs to know the chip's write timing.

## Interface
- `AW`, 2: FIFO depth is 2^AW entries (4 by default).
- `ADR_WAIT`, 6: `cen` ticks idled after an address strobe (1..255).
- `DATA_WAIT`, 24: `cen` ticks idled after a data strobe (1..255).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: chip clock enable; the same signal that feeds jt03.
- `flush` in 1: synchronous; discards all queued entries.
- `req_valid` in 1: a host write request is present.
- `req_ready` out 1: the FIFO has space.
- `req_reg` in 8: YM2203 register number.
- `req_val` in 8: value to write.
- `fifo_level` out AW+1: current number of queued entries.
- `busy` out 1: a sequence is in progress or the FIFO is non-empty.
- `chip_din` out 8: drives jt03 `din`.
- `chip_addr` out 1: drives jt03 `addr`.
- `chip_cs_n` out 1: drives jt03 `cs_n`.
- `chip_wr_n` out 1: drives jt03 `wr_n`.

## Operation
- Host side runs every `clk`, with no `cen` gating.
  - Push when `req_valid && req_ready`.
  - `req_ready = (fifo_level != 2^AW)`.
- Sequencer FSM advances only on `clk` edges where `cen=1`. States:
  - IDLE: chip bus inactive (`cs_n=1`, `wr_n=1`, `addr=0`, `din=0`). If the FIFO is non-empty, pop the head into holding registers and go to ADR.
  - ADR: `cs_n=0`, `wr_n=0`, `addr=0`, `din=reg`. Lasts exactly 1 tick, then go to AWAIT with the counter loaded to ADR_WAIT-1.
  - AWAIT: bus inactive, `din` holds `reg`. Decrement the counter each tick. When the counter is 0, go to DAT.
  - DAT: `cs_n=0`, `wr_n=0`, `addr=1`, `din=val`. Lasts 1 tick, then go to DWAIT with the counter loaded to DATA_WAIT-1.
  - DWAIT: bus inactive, `din` holds `val`. When the counter is 0, go to IDLE.
- `busy = (state != IDLE) || (fifo_level != 0)`.
- Simultaneous push and pop in the same cycle:
  - Allowed; the level is unchanged.
  - On a full FIFO a push cannot coincide, because `req_ready=0`.
- `flush`:
  - Clears the FIFO pointers and level on that `clk` edge, and overrides any push in the same cycle.
  - A sequence already past IDLE runs to the end of DWAIT. A half-written register (address without data) is never left on the chip.
  - A pop on the same `cen` edge as `flush` is still taken, since that entry has already left the FIFO.
- Counter width is 8 bits. Parameter values of 0 are illegal; a simulation assertion enforces this.

## Timing
- Reset values:
  - `chip_cs_n=1`, `chip_wr_n=1`, `chip_addr=0`, `chip_din=0`.
  - `req_ready=1`, `fifo_level=0`, `busy=0`, state IDLE.
- Reset applies asynchronously at any point, including mid-strobe. The bus releases immediately and all queued entries are lost.
- Push to `fifo_level` increment: 1 `clk`.
- Latency from push into an empty, IDLE block to the ADR strobe:
  - The first `cen` edge after the push cycle enters ADR.
  - The strobe outputs are registered, valid from that edge to the next `cen` edge.
- Strobe width: exactly 1 `cen` period for both ADR and DAT.
- Write-to-write spacing, ADR edge to next ADR edge, with a back-to-back queue: `1 + ADR_WAIT + 1 + DATA_WAIT + 1` `cen` ticks. With defaults this is 33.
- With `cen` held low, the FSM freezes and the outputs hold; host pushes continue.

## Structure
- Package `jt03_wrseq_pkg` holds:
  - the state encoding (IDLE, ADR, AWAIT, DAT, DWAIT; 3 bits);
  - default wait constants;
  - the 16-bit entry layout {reg, val}.
- Sub-module `jt03_wrseq_fifo`:
  - synchronous FIFO, 16-bit wide, depth 2^AW;
  - push/pop/flush inputs; level/full/empty outputs;
  - first-word data is visible combinationally for the pop.
- The top level holds the FSM, the wait counter and the output registers.

## Test plan
- Single write: push (0x28, 0xF1) with `cen` every 2 `clk`.
  - ADR strobe with `din=0x28`, `addr=0` for one `cen` period.
  - 6 idle ticks.
  - DAT strobe with `din=0xF1`, `addr=1`.
  - 24 idle ticks, then `busy` falls.
- Fill: push 5 entries back-to-back with no `cen`.
  - `req_ready` goes low after the 4th push; the 5th is held.
  - `fifo_level=4`.
  - Enabling `cen` then produces 4 sequences spaced exactly 33 ticks apart, in order.
- Simultaneous push/pop: with 1 entry queued, push on the same `clk` as the IDLE pop.
  - `fifo_level` stays 1.
  - Both entries are written in order.
- Flush mid-sequence: with 3 entries queued, assert `flush` during AWAIT.
  - The current entry completes both strobes.
  - `fifo_level=0`, and no further strobes occur.
- Reset mid-strobe: assert `rst` during DAT.
  - `chip_cs_n` and `chip_wr_n` go to 1 in the same cycle, before any clock edge.
  - All outputs return to their reset values.
- `cen` stall: hold `cen=0` for 50 `clk` during DWAIT.
  - State and outputs are frozen.
  - The remaining tick count resumes unchanged.
